// File: rtl/sd_session_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_session_controller_pkg
// Description : State encoding shared by the SD session sequencer and the
//               board top level, which decodes the state onto LEDs.
//               No ports; provides sd_state_t and is_stable_state().
// Revision    : 1.0 - initial release
// ============================================================================
package sd_session_controller_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_SUB_RST    = 4'd1,
    ST_INIT_START = 4'd2,
    ST_INIT_WAIT  = 4'd3,
    ST_READ_START = 4'd4,
    ST_READ_WAIT  = 4'd5,
    ST_DRAIN      = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERROR      = 4'd8
  } sd_state_t;

  // Resting states: the only ones that accept a new start and report not-busy.
  function automatic logic is_stable_state(input logic [3:0] s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_session_controller_timeout.sv
`default_nettype none
// ============================================================================
// Module      : sd_timeout_counter
// Description : Wait-state timeout counter shared by the init and read waits.
//               Counts while enabled; expired is high in the cycle where the
//               count equals limit-1, so the owner leaves the wait on the
//               limit-th cycle after entry.
// Ports       : clock, reset (async, active-low), clear, enable,
//               limit[TMO_W-1:0] in; expired out.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_timeout_counter #(
  parameter int TMO_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + TMO_W'(1);
    end
  end

  assign expired = enable && (r_count == (limit - TMO_W'(1)));

endmodule
`default_nettype wire

// File: rtl/sd_session_controller.sv
`default_nettype none
// ============================================================================
// Module      : sd_session_controller
// Description : Sequencer for one SD-card read session: resets and starts the
//               card initializer, waits for ready with timeout/retry, then
//               issues block_count single-block reads, draining the byte FIFO
//               after each. Also muxes MOSI/CS between the two SPI masters.
// Ports       : clock, reset (async, active-low), start, abort, block_count,
//               init_ready/init_mosi/init_cs, rd_busy/rd_mosi/rd_cs,
//               fifo_empty in; init_start, rd_start, sub_reset, cs, mosi,
//               busy, done, error, blocks_done, state out.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_session_controller
  import sd_session_controller_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int INIT_TIMEOUT = 4096,
  parameter int READ_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3,
  parameter int TMO_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] block_count,
  input  logic             init_ready,
  input  logic             init_mosi,
  input  logic             init_cs,
  input  logic             rd_busy,
  input  logic             rd_mosi,
  input  logic             rd_cs,
  input  logic             fifo_empty,
  output logic             init_start,
  output logic             rd_start,
  output logic             sub_reset,
  output logic             cs,
  output logic             mosi,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] blocks_done,
  output logic [3:0]       state
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  sd_state_t          r_state;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_blocks_done;
  logic [RETRY_W-1:0] r_retry;
  logic               r_seen_busy;

  logic               w_in_init_wait;
  logic               w_in_read_wait;
  logic [TMO_W-1:0]   w_tmo_limit;
  logic               w_expired;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic [CNT_W-1:0]   w_blocks_nxt;

  assign w_in_init_wait = (r_state == ST_INIT_WAIT);
  assign w_in_read_wait = (r_state == ST_READ_WAIT);
  assign w_tmo_limit    = w_in_init_wait ? TMO_W'(INIT_TIMEOUT) : TMO_W'(READ_TIMEOUT);
  assign w_retry_nxt    = r_retry + RETRY_W'(1);
  assign w_blocks_nxt   = r_blocks_done + CNT_W'(1);

  // Held clear outside the waits, so every wait entry starts from zero.
  sd_timeout_counter #(
    .TMO_W (TMO_W)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (!(w_in_init_wait || w_in_read_wait)),
    .enable  (w_in_init_wait || w_in_read_wait),
    .limit   (w_tmo_limit),
    .expired (w_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_blocks_done <= '0;
      r_retry       <= '0;
      r_seen_busy   <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_count       <= block_count;
            r_blocks_done <= '0;
            r_retry       <= '0;
            r_state       <= ST_SUB_RST;
          end
        end
        ST_SUB_RST:    r_state <= ST_INIT_START;
        ST_INIT_START: r_state <= ST_INIT_WAIT;
        ST_INIT_WAIT: begin
          // Completion is checked first so a ready on the last cycle still counts.
          if (init_ready) begin
            r_state <= (r_count == '0) ? ST_DONE : ST_READ_START;
          end else if (w_expired) begin
            r_retry <= w_retry_nxt;
            r_state <= (w_retry_nxt < RETRY_W'(MAX_RETRY)) ? ST_SUB_RST : ST_ERROR;
          end
        end
        ST_READ_START: begin
          r_seen_busy <= 1'b0;
          r_state     <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          if (rd_busy) begin
            r_seen_busy <= 1'b1;
          end
          // A busy high-then-low edge marks the end of the block transfer.
          if (r_seen_busy && !rd_busy) begin
            r_state <= ST_DRAIN;
          end else if (w_expired) begin
            r_state <= ST_ERROR;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            r_blocks_done <= w_blocks_nxt;
            r_state       <= (w_blocks_nxt == r_count) ? ST_DONE : ST_READ_START;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign state       = r_state;
  assign blocks_done = r_blocks_done;
  assign sub_reset   = (r_state == ST_IDLE) || (r_state == ST_SUB_RST);
  assign init_start  = (r_state == ST_INIT_START);
  assign rd_start    = (r_state == ST_READ_START);
  assign busy        = !is_stable_state(r_state);
  assign done        = (r_state == ST_DONE);
  assign error       = (r_state == ST_ERROR);

  // A master owns the bus only while it is actively working; otherwise the
  // card is deselected with MOSI idling high.
  always_comb begin
    mosi = 1'b1;
    cs   = 1'b1;
    if (w_in_init_wait && !init_ready) begin
      mosi = init_mosi;
      cs   = init_cs;
    end else if (w_in_read_wait && rd_busy) begin
      mosi = rd_mosi;
      cs   = rd_cs;
    end
  end

endmodule
`default_nettype wire
